// File: rtl/fft_peak_detect_pkg.sv
`default_nettype none
// =============================================================================
// fft_peak_detect_pkg : state encoding and default widths shared with the FFT
// front-end.  Rev 1.0
// =============================================================================
package fft_peak_detect_pkg;

  localparam int FPD_DATA_W = 16;
  localparam int FPD_IDX_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } fpd_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_mag2_pipe.sv
`default_nettype none
// =============================================================================
// fft_mag2_pipe : re^2 + im^2 in three register stages, valid and tag follow.
// Rev 1.0
// =============================================================================
module fft_mag2_pipe
  import fft_peak_detect_pkg::*;
#(
  parameter int DATA_W = FPD_DATA_W,
  parameter int TAG_W  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_re,
  input  logic [DATA_W-1:0]     in_im,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_pow,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int PW = 2 * DATA_W;

  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic [DATA_W-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, s3_tag_q, s3_tag_d;
  logic [PW-1:0]     s2_sqr_q, s2_sqr_d, s2_sqi_q, s2_sqi_d, s3_pow_q, s3_pow_d;
  logic [PW-1:0]     w_re_ext, w_im_ext;

  // Squares stay below 2^PW, so the low PW bits of the unsigned product are exact.
  assign w_re_ext = {{DATA_W{s1_re_q[DATA_W-1]}}, s1_re_q};
  assign w_im_ext = {{DATA_W{s1_im_q[DATA_W-1]}}, s1_im_q};

  always_comb begin
    s1_valid_d = in_valid;
    s1_re_d    = in_re;
    s1_im_d    = in_im;
    s1_tag_d   = in_tag;
    s2_valid_d = s1_valid_q;
    s2_sqr_d   = w_re_ext * w_re_ext;
    s2_sqi_d   = w_im_ext * w_im_ext;
    s2_tag_d   = s1_tag_q;
    s3_valid_d = s2_valid_q;
    s3_pow_d   = s2_sqr_q + s2_sqi_q;
    s3_tag_d   = s2_tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sqr_q   <= '0;
      s2_sqi_q   <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_pow_q   <= '0;
      s3_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sqr_q   <= s2_sqr_d;
      s2_sqi_q   <= s2_sqi_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_pow_q   <= s3_pow_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_pow   = s3_pow_q;
  assign out_tag   = s3_tag_q;

endmodule
`default_nettype wire

// File: rtl/fft_peak_detect.sv
`default_nettype none
// =============================================================================
// fft_peak_detect : finds the strongest bin in 1..N/2-1 of each FFT frame.
// Rev 1.0
// =============================================================================
module fft_peak_detect
  import fft_peak_detect_pkg::*;
#(
  parameter int DATA_W = FPD_DATA_W,
  parameter int FFT_N  = 1024,
  parameter int IDX_W  = FPD_IDX_W
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [DATA_W-1:0]   s_re,
  input  logic [DATA_W-1:0]   s_im,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [IDX_W-1:0]    peak_idx,
  output logic [2*DATA_W-1:0] peak_pow,
  output logic                peak_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int PW = 2 * DATA_W;

  fpd_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, run_idx_q, run_idx_d, peak_idx_q, peak_idx_d;
  logic [PW-1:0]    run_pow_q, run_pow_d, peak_pow_q, peak_pow_d;
  logic [1:0]       drain_q, drain_d;
  logic             bad_q, bad_d, en_q, en_d;

  logic             w_accept, w_at_end, w_last, w_elig, w_hit;
  logic             p_valid;
  logic [PW-1:0]    p_pow;
  logic [IDX_W:0]   p_tag;
  logic [IDX_W-1:0] w_best_idx;
  logic [PW-1:0]    w_best_pow;

  assign w_accept = s_valid & s_ready;
  assign w_at_end = (cnt_q == IDX_W'(FFT_N - 1));
  // A frame also ends when the counter runs out, so no beat leaks into the next frame.
  assign w_last   = w_accept & (s_last | w_at_end);
  assign w_elig   = (cnt_q != '0) && (cnt_q < IDX_W'(FFT_N / 2));

  fft_mag2_pipe #(.DATA_W(DATA_W), .TAG_W(IDX_W + 1)) u_mag2 (
    .clk       (sys_clk),
    .rst_n     (sys_rst),
    .in_valid  (w_accept),
    .in_re     (s_re),
    .in_im     (s_im),
    .in_tag    ({w_elig, cnt_q}),
    .out_valid (p_valid),
    .out_pow   (p_pow),
    .out_tag   (p_tag)
  );

  // Strictly greater keeps the lowest index on ties.
  assign w_hit      = p_valid && p_tag[IDX_W] && (p_pow > run_pow_q);
  assign w_best_idx = w_hit ? p_tag[IDX_W-1:0] : run_idx_q;
  assign w_best_pow = w_hit ? p_pow : run_pow_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (w_last)        state_d = ST_DRAIN;
        else if (w_accept) state_d = ST_ACCUM;
      end
      ST_DRAIN:  if (drain_q == 2'd2) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d       = 1'b1;
    cnt_d      = cnt_q;
    drain_d    = (state_q == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
    bad_d      = bad_q;
    run_idx_d  = w_best_idx;
    run_pow_d  = w_best_pow;
    peak_idx_d = peak_idx_q;
    peak_pow_d = peak_pow_q;
    if (state_q == ST_REPORT) begin
      cnt_d     = '0;
      run_idx_d = '0;
      run_pow_d = '0;
    end else if (w_accept) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
    if (w_last) bad_d = s_last ^ w_at_end;
    // The final beat leaves the pipe in the last DRAIN cycle, so take the bypassed best.
    if ((state_q == ST_DRAIN) && (drain_q == 2'd2) && !bad_q) begin
      peak_idx_d = w_best_idx;
      peak_pow_d = w_best_pow;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      drain_q    <= 2'd0;
      bad_q      <= 1'b0;
      run_idx_q  <= '0;
      run_pow_q  <= '0;
      peak_idx_q <= '0;
      peak_pow_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      bad_q      <= bad_d;
      run_idx_q  <= run_idx_d;
      run_pow_q  <= run_pow_d;
      peak_idx_q <= peak_idx_d;
      peak_pow_q <= peak_pow_d;
    end
  end

  always_comb begin
    s_ready    = en_q && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
    busy       = (state_q != ST_IDLE);
    peak_valid = (state_q == ST_REPORT) && !bad_q;
    frame_err  = (state_q == ST_REPORT) && bad_q;
  end

  assign peak_idx = peak_idx_q;
  assign peak_pow = peak_pow_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detect.sv
`default_nettype none
// Testbench for fft_peak_detect: frame-level reference model checked every cycle,
// plus directed frames with hand-computed peaks, latencies and error pulses.
module tb_fft_peak_detect;

  localparam int DATA_W = 16;
  localparam int FFT_N  = 1024;
  localparam int IDX_W  = 10;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b0;
  logic [DATA_W-1:0]   s_re = '0, s_im = '0;
  logic                s_valid = 1'b0, s_last = 1'b0;
  logic                s_ready, peak_valid, frame_err, busy;
  logic [IDX_W-1:0]    peak_idx;
  logic [2*DATA_W-1:0] peak_pow;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DATA_W-1:0] drv_re [FFT_N];
  logic signed [DATA_W-1:0] drv_im [FFT_N];

  fft_peak_detect #(.DATA_W(DATA_W), .FFT_N(FFT_N), .IDX_W(IDX_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_re(s_re), .s_im(s_im),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .peak_idx(peak_idx), .peak_pow(peak_pow), .peak_valid(peak_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model: one frame buffer and a post-frame countdown
  int     m_re [FFT_N];
  int     m_im [FFT_N];
  bit     m_started = 0, m_active = 0, m_good = 0;
  int     m_cd = 0, m_bin = 0, m_pidx = 0;
  longint m_ppow = 0;

  task automatic model_clear();
    for (int k = 0; k < FFT_N; k++) begin
      m_re[k] = 0;
      m_im[k] = 0;
    end
    m_bin = 0;
  endtask

  always @(negedge sys_clk) begin
    bit e_ready, e_busy, e_pv, e_fe;
    longint p, best_p;
    int best_i;
    if (!sys_rst) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_peak_valid", peak_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_peak_idx", peak_idx, 0);
      chk("rst_peak_pow", peak_pow, 0);
      m_started = 0; m_active = 0; m_cd = 0; m_pidx = 0; m_ppow = 0;
      model_clear();
    end else begin
      e_ready = m_started && (m_cd == 0);
      e_busy  = m_active || (m_cd != 0);
      e_pv    = (m_cd == 4) && m_good;
      e_fe    = (m_cd == 4) && !m_good;
      if (e_pv) begin
        best_i = 0; best_p = 0;
        for (int k = 1; k < FFT_N / 2; k++) begin
          p = longint'(m_re[k]) * m_re[k] + longint'(m_im[k]) * m_im[k];
          if (p > best_p) begin
            best_p = p;
            best_i = k;
          end
        end
        m_pidx = best_i;
        m_ppow = best_p;
      end
      chk("s_ready", s_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("peak_valid", peak_valid, e_pv);
      chk("frame_err", frame_err, e_fe);
      chk("peak_idx", peak_idx, m_pidx);
      chk("peak_pow", peak_pow, m_ppow);
      if (s_valid && e_ready) begin
        m_re[m_bin] = int'($signed(s_re));
        m_im[m_bin] = int'($signed(s_im));
        m_active = 1;
        if (s_last || (m_bin == FFT_N - 1)) begin
          m_good   = s_last && (m_bin == FFT_N - 1);
          m_cd     = 1;
          m_active = 0;
        end else begin
          m_bin++;
        end
      end else if (m_cd == 4) begin
        m_cd = 0;
        model_clear();
      end else if (m_cd != 0) begin
        m_cd++;
      end
      m_started = 1;
    end
  end

  // ---------------- stimulus helpers
  task automatic clear_frame();
    for (int k = 0; k < FFT_N; k++) begin
      drv_re[k] = '0;
      drv_im[k] = '0;
    end
  endtask

  task automatic send_frame(input string nm, input int nbeats, input int last_at, input bit gaps);
    int b = 0;
    int guard = 0;
    while (b < nbeats && guard < 4 * FFT_N) begin
      @(posedge sys_clk); #1;
      guard++;
      if (gaps && (guard % 97 == 3)) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_re    = drv_re[b];
        s_im    = drv_im[b];
        s_last  = (b == last_at);
      end
      @(negedge sys_clk);
      if (s_valid && s_ready) b++;
    end
    chk({nm, "_beats"}, b, nbeats);
  endtask

  // Holds junk on the bus while not ready, returns which post-frame cycle pulsed.
  task automatic drain_watch(input string nm, output int seen_pv, output int seen_fe);
    seen_pv = -1;
    seen_fe = -1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge sys_clk); #1;
      s_valid = (k <= 3);
      s_re    = 16'h7fff;
      s_im    = 16'h7fff;
      s_last  = 1'b1;
      @(negedge sys_clk);
      if (peak_valid && seen_pv < 0) seen_pv = k;
      if (frame_err && seen_fe < 0) seen_fe = k;
      if (k == 5) chk({nm, "_ready_T5"}, s_ready, 1);
    end
    s_last = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pv, fe;
    clear_frame();
    repeat (3) @(negedge sys_clk);
    chk("init_peak_idx", peak_idx, 0);
    chk("init_s_ready", s_ready, 0);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("release_ready_before_edge", s_ready, 0);
    @(negedge sys_clk);
    chk("release_ready_after_edge", s_ready, 1);

    // single peak at bin 37, with valid gaps
    clear_frame();
    drv_re[37] = 16'sd1000; drv_im[37] = -16'sd500;
    send_frame("t37", FFT_N, FFT_N - 1, 1'b1);
    drain_watch("t37", pv, fe);
    chk("t37_latency", pv, 4);
    chk("t37_no_err", fe, -1);
    chk("t37_idx", peak_idx, 37);
    chk("t37_pow", peak_pow, 1250000);

    // tie between bins 5 and 9
    clear_frame();
    drv_re[5] = 16'sd200; drv_re[9] = 16'sd200;
    send_frame("tie", FFT_N, FFT_N - 1, 1'b0);
    drain_watch("tie", pv, fe);
    chk("tie_latency", pv, 4);
    chk("tie_idx", peak_idx, 5);
    chk("tie_pow", peak_pow, 40000);

    // short frame: s_last on beat 511
    clear_frame();
    drv_re[20] = 16'sd5000;
    send_frame("short", 512, 511, 1'b0);
    drain_watch("short", pv, fe);
    chk("short_err_cycle", fe, 4);
    chk("short_no_valid", pv, -1);
    chk("short_idx_held", peak_idx, 5);
    chk("short_pow_held", peak_pow, 40000);

    // DC and upper half excluded
    clear_frame();
    drv_re[0] = 16'sd30000; drv_re[600] = 16'sd30000;
    send_frame("dc", FFT_N, FFT_N - 1, 1'b0);
    drain_watch("dc", pv, fe);
    chk("dc_latency", pv, 4);
    chk("dc_idx", peak_idx, 0);
    chk("dc_pow", peak_pow, 0);

    // worst-case magnitude
    clear_frame();
    drv_re[100] = -16'sd32768; drv_im[100] = -16'sd32768;
    send_frame("max", FFT_N, FFT_N - 1, 1'b0);
    drain_watch("max", pv, fe);
    chk("max_latency", pv, 4);
    chk("max_idx", peak_idx, 100);
    chk("max_pow", peak_pow, 64'd2147483648);

    // counter runs out without s_last
    clear_frame();
    drv_re[7] = 16'sd10;
    send_frame("over", FFT_N, -1, 1'b0);
    drain_watch("over", pv, fe);
    chk("over_err_cycle", fe, 4);
    chk("over_no_valid", pv, -1);
    chk("over_idx_held", peak_idx, 100);

    // reset in the middle of a frame
    clear_frame();
    drv_re[50] = 16'sd3000;
    send_frame("mid", 300, -1, 1'b0);
    @(posedge sys_clk); #1;
    s_valid = 1'b0;
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("midrst_idx", peak_idx, 0);
    chk("midrst_pow", peak_pow, 0);
    chk("midrst_busy", busy, 0);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    clear_frame();
    drv_re[12] = 16'sd100; drv_im[12] = 16'sd100;
    send_frame("b12", FFT_N, FFT_N - 1, 1'b0);
    drain_watch("b12", pv, fe);
    chk("b12_latency", pv, 4);
    chk("b12_idx", peak_idx, 12);
    chk("b12_pow", peak_pow, 20000);

    repeat (3) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
